flex_downsample_stream: RTL and testbench

Streaming, multi-channel successor to the fixed-geometry combinational bilinear downsampler in the flexible-downsampling layer. It accepts a raster-order feature map one pixel per handshake and applies bilinear resampling with a run-time Q8.8 stride, producing a raster-order output map. It buffers only two input rows and uses valid/ready handshakes on both sides. It sits between the token-reshape stage and the next transformer stage, and replaces per-shape generated instances with one configurable block.

---
 rtl/flex_ds_pkg.sv | 23 ++
 rtl/bilinear_interp_pipe.sv | 51 +++++
 rtl/flex_downsample_stream.sv | 190 +++++++++++++++++++
 tb/tb_flex_downsample_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/flex_ds_pkg.sv
// Shared types and constants for the streaming bilinear downsampler.
// Holds the frame FSM states, Q8.8 constants and the config legality rule.
package flex_ds_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_EMIT,
      S_DRAIN
   } ds_state_e;

   localparam int ONE_Q8_8   = 256;
   localparam int STRIDE_MAX = 511;
   localparam int ROUND_Q16  = 32768;

   function automatic logic cfg_legal(input int stride, input int hin,
                                      input int hout, input int hin_max);
      return (stride >= ONE_Q8_8) && (stride <= STRIDE_MAX) &&
             (hin >= 2) && (hin <= hin_max) &&
             (hout >= 1) && (hout <= hin);
   endfunction

endpackage

// File: rtl/bilinear_interp_pipe.sv
// One-channel bilinear blend: horizontal lerp in stage 1, vertical lerp plus rounding in stage 2.
// Latency 2 cycles; both stages freeze while stall is high.
module bilinear_interp_pipe
   import flex_ds_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              in_vld,
   input  logic [DATA_W-1:0] a00,
   input  logic [DATA_W-1:0] a01,
   input  logic [DATA_W-1:0] a10,
   input  logic [DATA_W-1:0] a11,
   input  logic [7:0]        fx,
   input  logic [7:0]        fy,
   output logic              out_vld,
   output logic [DATA_W-1:0] out_dat
);
   localparam int IW = DATA_W + 18;

   logic [IW-1:0] h0, h1, h0_q, h1_q, sum;
   logic [7:0]    fy_q;
   logic          vld_q;

   always_comb begin
      h0  = IW'(a00) * (IW'(ONE_Q8_8) - IW'(fx)) + IW'(a01) * IW'(fx);
      h1  = IW'(a10) * (IW'(ONE_Q8_8) - IW'(fx)) + IW'(a11) * IW'(fx);
      sum = h0_q * (IW'(ONE_Q8_8) - IW'(fy_q)) + h1_q * IW'(fy_q) + IW'(ROUND_Q16);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q   <= 1'b0;
         h0_q    <= '0;
         h1_q    <= '0;
         fy_q    <= '0;
         out_vld <= 1'b0;
         out_dat <= '0;
      end else if (!stall) begin
         vld_q   <= in_vld;
         h0_q    <= h0;
         h1_q    <= h1;
         fy_q    <= fy;
         out_vld <= vld_q;
         out_dat <= DATA_W'(sum >> 16);
      end
   end

endmodule

// File: rtl/flex_downsample_stream.sv
// Streaming multi-channel bilinear downsampler with run-time Q8.8 stride and two-row line buffer.
// Output 2 cycles after buffer read; pipe stalls on !out_ready, input stalls while rows are emitted.
module flex_downsample_stream
   import flex_ds_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int CHANNELS = 1,
   parameter int HIN_MAX  = 64,
   parameter int DIM_W    = $clog2(HIN_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [DIM_W-1:0]             cfg_hin,
   input  logic [DIM_W-1:0]             cfg_hout,
   input  logic [15:0]                  cfg_stride,
   output logic                         busy,
   output logic                         done,
   output logic                         cfg_err,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [CHANNELS*DATA_W-1:0]   in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [CHANNELS*DATA_W-1:0]   out_data,
   output logic                         out_last
);
   localparam int PW = CHANNELS * DATA_W;
   localparam int AW = (HIN_MAX > 1) ? $clog2(HIN_MAX) : 1;
   localparam logic [DIM_W-1:0] ONE_D = DIM_W'(1);

   ds_state_e        state;
   logic [DIM_W-1:0] hin, hout, hin_m1, in_col, rows_recv, col_j, row_i;
   logic [DIM_W-1:0] cr, fc, cc, tgt;
   logic [15:0]      stride;
   logic [23:0]      acc_r, acc_c, stride24;
   logic             fr_odd, last_seen, last1;
   logic             adv, issue, issue_last, in_fire, out_fire, drain_now;
   logic [PW-1:0]    lb0 [HIN_MAX];
   logic [PW-1:0]    lb1 [HIN_MAX];
   logic [PW-1:0]    r00, r01, r10, r11;
   logic [CHANNELS-1:0] vld_all;

   function automatic logic [DIM_W-1:0] clamp_pos(input logic [15:0] p,
                                                  input logic [DIM_W-1:0] lim);
      return (p > 16'(lim)) ? lim : p[DIM_W-1:0];
   endfunction

   assign hin_m1   = hin - ONE_D;
   assign stride24 = {8'd0, stride};
   assign cr       = clamp_pos(acc_r[23:8] + 16'd1, hin_m1);
   assign fc       = clamp_pos(acc_c[23:8], hin_m1);
   assign cc       = clamp_pos(acc_c[23:8] + 16'd1, hin_m1);
   assign tgt      = cr + ONE_D;
   // Floor row is ceil-1, or ceil itself once both are clamped to the last row.
   assign fr_odd   = (acc_r[23:8] >= 16'(hin_m1)) ? cr[0] : ~cr[0];

   assign adv        = !out_valid || out_ready;
   assign issue      = (state == S_EMIT) && adv;
   assign issue_last = issue && (col_j == hout - ONE_D) && (row_i == hout - ONE_D);
   assign in_ready   = ((state == S_FILL) && (rows_recv != tgt)) ||
                       ((state == S_DRAIN) && (rows_recv != hin));
   assign in_fire    = in_valid && in_ready;
   assign out_fire   = out_valid && out_ready;
   assign drain_now  = (rows_recv == hin) ||
                       (in_fire && (rows_recv == hin_m1) && (in_col == hin_m1));

   always_ff @(posedge clk) begin
      if (in_fire && (state == S_FILL)) begin
         if (rows_recv[0]) lb1[in_col[AW-1:0]] <= in_data;
         else              lb0[in_col[AW-1:0]] <= in_data;
      end
   end

   always_comb begin
      r00 = fr_odd ? lb1[fc[AW-1:0]] : lb0[fc[AW-1:0]];
      r01 = fr_odd ? lb1[cc[AW-1:0]] : lb0[cc[AW-1:0]];
      r10 = cr[0]  ? lb1[fc[AW-1:0]] : lb0[fc[AW-1:0]];
      r11 = cr[0]  ? lb1[cc[AW-1:0]] : lb0[cc[AW-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         hin       <= '0;
         hout      <= '0;
         stride    <= '0;
         in_col    <= '0;
         rows_recv <= '0;
         col_j     <= '0;
         row_i     <= '0;
         acc_r     <= '0;
         acc_c     <= '0;
         last_seen <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (out_fire && out_last) last_seen <= 1'b1;
         if (in_fire) begin
            if (in_col == hin_m1) begin
               in_col    <= '0;
               rows_recv <= rows_recv + ONE_D;
            end else begin
               in_col <= in_col + ONE_D;
            end
         end
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_legal(int'(cfg_stride), int'(cfg_hin), int'(cfg_hout), HIN_MAX)) begin
                     hin       <= cfg_hin;
                     hout      <= cfg_hout;
                     stride    <= cfg_stride;
                     in_col    <= '0;
                     rows_recv <= '0;
                     col_j     <= '0;
                     row_i     <= '0;
                     acc_r     <= '0;
                     acc_c     <= '0;
                     last_seen <= 1'b0;
                     busy      <= 1'b1;
                     state     <= S_FILL;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_FILL: begin
               if (rows_recv == tgt) state <= S_EMIT;
            end
            S_EMIT: begin
               if (issue) begin
                  if (col_j == hout - ONE_D) begin
                     col_j <= '0;
                     acc_c <= '0;
                     acc_r <= acc_r + stride24;
                     row_i <= row_i + ONE_D;
                     state <= (row_i == hout - ONE_D) ? S_DRAIN : S_FILL;
                  end else begin
                     col_j <= col_j + ONE_D;
                     acc_c <= acc_c + stride24;
                  end
               end
            end
            S_DRAIN: begin
               // Finish only once both the final output and the final input beat are gone.
               if ((last_seen || (out_fire && out_last)) && drain_now) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last1    <= 1'b0;
         out_last <= 1'b0;
      end else if (adv) begin
         last1    <= issue_last;
         out_last <= last1;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      bilinear_interp_pipe #(.DATA_W(DATA_W)) u_pipe (
         .clk     (clk),
         .rst_n   (rst_n),
         .stall   (!adv),
         .in_vld  (issue),
         .a00     (r00[c*DATA_W +: DATA_W]),
         .a01     (r01[c*DATA_W +: DATA_W]),
         .a10     (r10[c*DATA_W +: DATA_W]),
         .a11     (r11[c*DATA_W +: DATA_W]),
         .fx      (acc_c[7:0]),
         .fy      (acc_r[7:0]),
         .out_vld (vld_all[c]),
         .out_dat (out_data[c*DATA_W +: DATA_W])
      );
   end

   assign out_valid = &vld_all;

endmodule

// File: tb/tb_flex_downsample_stream.sv
// Randomized bench for flex_downsample_stream against a direct-formula bilinear reference.
module tb_flex_downsample_stream;
   localparam int DATA_W   = 8;
   localparam int CHANNELS = 2;
   localparam int HIN_MAX  = 64;
   localparam int DIM_W    = $clog2(HIN_MAX + 1);
   localparam int PW       = CHANNELS * DATA_W;

   typedef struct {
      logic [PW-1:0] dat;
      logic          last;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [DIM_W-1:0] cfg_hin = '0;
   logic [DIM_W-1:0] cfg_hout = '0;
   logic [15:0]      cfg_stride = '0;
   logic             busy, done, cfg_err;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [PW-1:0]    in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [PW-1:0]    out_data;
   logic             out_last;

   flex_downsample_stream #(
      .DATA_W(DATA_W), .CHANNELS(CHANNELS), .HIN_MAX(HIN_MAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_hin(cfg_hin), .cfg_hout(cfg_hout), .cfg_stride(cfg_stride),
      .busy(busy), .done(done), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last)
   );

   always #5 clk = ~clk;

   int            tests = 0, fails = 0;
   exp_t          exp_q[$];
   exp_t          mon_e;
   logic [PW-1:0] img [HIN_MAX*HIN_MAX];
   int            src_idx = 0, src_total = 0, n_out = 0, n_exp = 0, done_cnt = 0;
   bit            done_seen = 0;
   logic          prev_stall = 1'b0;
   logic [PW-1:0] prev_dat = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   // Reference: bilinear sample at (stride*i/256, stride*j/256), indices clamped to the map.
   function automatic void build_expect(input int h_in, input int h_out, input int strd);
      exp_t e;
      int fr, cr, fc, cc, fx, fy, a00, a01, a10, a11, v;
      exp_q.delete();
      for (int i = 0; i < h_out; i++) begin
         fy = (strd * i) % 256;
         fr = imin((strd * i) / 256, h_in - 1);
         cr = imin((strd * i) / 256 + 1, h_in - 1);
         for (int j = 0; j < h_out; j++) begin
            fx = (strd * j) % 256;
            fc = imin((strd * j) / 256, h_in - 1);
            cc = imin((strd * j) / 256 + 1, h_in - 1);
            for (int c = 0; c < CHANNELS; c++) begin
               a00 = int'(img[fr*h_in + fc][c*DATA_W +: DATA_W]);
               a01 = int'(img[fr*h_in + cc][c*DATA_W +: DATA_W]);
               a10 = int'(img[cr*h_in + fc][c*DATA_W +: DATA_W]);
               a11 = int'(img[cr*h_in + cc][c*DATA_W +: DATA_W]);
               v = ((a00*(256-fx) + a01*fx)*(256-fy) + (a10*(256-fx) + a11*fx)*fy + 32768) / 65536;
               e.dat[c*DATA_W +: DATA_W] = DATA_W'(v);
            end
            e.last = (i == h_out - 1) && (j == h_out - 1);
            exp_q.push_back(e);
         end
      end
      n_exp = exp_q.size();
   endfunction

   task automatic prep(input int mode, input int h_in, input int h_out, input int strd);
      for (int r = 0; r < h_in; r++)
         for (int c = 0; c < h_in; c++)
            case (mode)
               0:       img[r*h_in + c] = {8'h80, 8'h80};
               1:       img[r*h_in + c] = {8'(r * 8), 8'(c * 8)};
               default: img[r*h_in + c] = PW'($urandom);
            endcase
      build_expect(h_in, h_out, strd);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, prev_dat);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               check("output_overrun", n_out, n_exp);
            end else begin
               mon_e = exp_q.pop_front();
               check($sformatf("out_data[%0d]", n_out - 1), out_data, mon_e.dat);
               check($sformatf("out_last[%0d]", n_out - 1), out_last, mon_e.last);
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_data;
         if (done) begin
            done_cnt++;
            done_seen = 1;
            check("done_outputs_left", exp_q.size(), 0);
            check("done_inputs_taken", src_idx, src_total);
            check("busy_at_done", busy, 1'b0);
         end
      end
   end

   task automatic pulse_start(input int h_in, input int h_out, input int strd, input bit legal);
      @(posedge clk); #1;
      cfg_hin = DIM_W'(h_in);
      cfg_hout = DIM_W'(h_out);
      cfg_stride = 16'(strd);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, legal);
      check("cfg_err_pulse", cfg_err, !legal);
      @(negedge clk);
      check("cfg_err_one_cycle", cfg_err, 1'b0);
      if (!legal) check("busy_stays_low", busy, 1'b0);
   endtask

   task automatic run_frame(input int h_in, input int h_out, input int strd,
                            input int rdy_pct, input int abort_at);
      int total, cyc, limit;
      total = h_in * h_in;
      cyc = 0;
      limit = 30 * total + 3000;
      src_total = total;
      src_idx = 0;
      n_out = 0;
      done_cnt = 0;
      done_seen = 0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      pulse_start(h_in, h_out, strd, 1'b1);
      while (!done_seen && cyc < limit) begin
         @(posedge clk); #1;
         if (abort_at >= 0 && n_out >= abort_at) begin
            rst_n = 1'b0;
            in_valid = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            check("abort_ctrl_zero", {busy, done, cfg_err, in_ready, out_valid, out_last}, 6'd0);
            check("abort_data_zero", out_data, '0);
            check("abort_output_index", n_out, abort_at);
            @(posedge clk); #1;
            rst_n = 1'b1;
            exp_q.delete();
            return;
         end
         in_valid = (src_idx < total) && ($urandom_range(99) < 85);
         in_data = (src_idx < total) ? img[src_idx] : '0;
         out_ready = ($urandom_range(99) < rdy_pct);
         @(negedge clk);
         if (in_valid && in_ready) src_idx++;
         cyc++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check("frame_done_seen", done_seen, 1'b1);
      repeat (4) @(negedge clk);
      check("done_pulses", done_cnt, 1);
      check("output_count", n_out, n_exp);
      check("busy_idle_after", busy, 1'b0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: simulation did not finish, limit 5 ms");
      $fatal(1, "global timeout");
   end

   initial begin
      int mism, hi, ho, st;
      repeat (3) @(negedge clk);
      check("reset_ctrl_zero", {busy, done, cfg_err, in_ready, out_valid, out_last}, 6'd0);
      check("reset_data_zero", out_data, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      pulse_start(27, 19, 200, 1'b0);
      pulse_start(10, 11, 300, 1'b0);
      pulse_start(1, 1, 256, 1'b0);
      pulse_start(20, 10, 512, 1'b0);
      pulse_start(20, 0, 300, 1'b0);

      prep(0, 27, 19, 369);
      check("model_const_count", exp_q.size(), 361);
      check("model_const_last", exp_q[360].last, 1'b1);
      check("model_const_val", exp_q[200].dat, 16'h8080);
      run_frame(27, 19, 369, 100, -1);

      prep(1, 27, 19, 369);
      check("model_ramp_col1", exp_q[19*7 + 1].dat[7:0], 12);
      check("model_ramp_col0", exp_q[19*5].dat[7:0], 0);
      run_frame(27, 19, 369, 100, -1);

      prep(2, 8, 8, 256);
      mism = 0;
      for (int k = 0; k < 64; k++) if (exp_q[k].dat !== img[k]) mism++;
      check("model_identity", mism, 0);
      run_frame(8, 8, 256, 100, -1);

      prep(0, 27, 19, 369);
      run_frame(27, 19, 369, 50, -1);

      for (int t = 0; t < 5; t++) begin
         hi = $urandom_range(20, 2);
         ho = $urandom_range(hi, 1);
         st = $urandom_range(511, 256);
         prep(2, hi, ho, st);
         run_frame(hi, ho, st, 60, -1);
      end
      prep(2, 64, 40, 409);
      run_frame(64, 40, 409, 70, -1);
      prep(2, 2, 2, 511);
      run_frame(2, 2, 511, 50, -1);

      prep(0, 27, 19, 369);
      run_frame(27, 19, 369, 100, 100);
      prep(2, 27, 19, 369);
      run_frame(27, 19, 369, 80, -1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
